cpu_fetch_queue: RTL and testbench
==================================

Name: cpu_fetch_queue

Overview:
- Instruction fetch front-end that sits between the instruction cache and decode.
- Owns the fetch PC and drives the cache's fetch address and stall.
- Captures returned instruction words, with their PCs, in a small first-word-fall-through FIFO for decode.
- Handles branch/jump redirects by flushing the FIFO and draining the cache safely before the PC changes.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset.
- DEPTH_LOG2, 2, log2 of FIFO depth; DEPTH = 1<<DEPTH_LOG2; DEPTH_LOG2 >= 1 is required.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- o_icache_pc  out  32  fetch address to cache; equals fetch_pc (combinational)
- o_icache_stall  out  1  stall to cache
- i_icache_rdata  in  32  instruction word from cache
- i_icache_ready  in  1  single-cycle pulse: i_icache_rdata is valid for o_icache_pc
- i_icache_bus_request  in  1  tap of the cache's bus request; high while a miss is in flight
- i_jump  in  1  redirect pulse from execute
- i_jump_pc  in  32  redirect target; low 2 bits ignored (forced 0)
- o_valid  out  1  FIFO head valid
- o_pc  out  32  PC of head entry
- o_instruction  out  32  instruction of head entry
- i_ready  in  1  decode accepts head when o_valid && i_ready

Behaviour:
- Reset (i_reset sampled high):
  - fetch_pc=RESET_PC, state=RUN, FIFO empty (count=0, rd/wr pointers 0), target=0, quiet=0.
  - Outputs: o_valid=0, o_pc=0, o_instruction=0, o_icache_stall=0.
  - Reset mid-operation discards FIFO contents and any pending redirect.
- FIFO:
  - DEPTH entries of {pc, instr}; count is DEPTH_LOG2+1 bits; pointers wrap modulo DEPTH.
  - o_valid = (count!=0). o_pc and o_instruction come from the head entry and are 0 when empty.
  - Pop when o_valid && i_ready. Push per the RUN rule below. Simultaneous push and pop leaves count unchanged.
  - Zero-latency path is not provided: an instruction pushed at edge N is visible on o_valid from cycle N onward.
- o_icache_stall = (state==FLUSH) || (count >= DEPTH-1), combinational.
  - The threshold covers the single response the cache may deliver after it samples stall low, so push-when-full cannot occur.
  - A push while count==DEPTH is an assertion failure; the push is dropped.
- State RUN:
  - On i_icache_ready: push {fetch_pc, i_icache_rdata}, and fetch_pc <= fetch_pc+4 on the same edge. The cache's hit path requires this same-edge advance.
  - fetch_pc changes only on i_icache_ready or redirect completion. This keeps the cache bus address stable during a miss.
  - On i_jump: target <= {i_jump_pc[31:2],2'b00}; FIFO cleared; quiet <= 0; state <= FLUSH. Jump has priority over a same-cycle push or pop; that push is discarded and fetch_pc is not advanced.
- State FLUSH:
  - Stall is high and fetch_pc is held at its old value.
  - Any i_icache_ready response is discarded (no push, no PC advance).
  - quiet counts consecutive cycles with !i_icache_ready && !i_icache_bus_request. It resets to 0 on any cycle where either is high.
  - When quiet reaches 2: fetch_pc <= target, quiet <= 0, state <= RUN.
  - i_jump in FLUSH: target updated to the new value, FIFO stays empty, quiet is not reset.
  - Decode sees o_valid=0 throughout FLUSH.
- The cache's post-reset initialisation issues no responses. The fetch unit simply waits in RUN with o_icache_pc=RESET_PC.

Test Plan:
- Reset then hit stream: cache pulses ready each cycle with words 0xA0..; i_ready=1 -> o_pc sequence 0x0,0x4,0x8,... with matching instructions, and o_icache_pc advances by 4 on each ready.
- Backpressure (DEPTH=4): i_ready=0 with continuous hits -> stall rises when count=3; count tops at 4; no overflow; releasing i_ready drains 4 entries in order.
- Miss hold: i_icache_bus_request high for 10 cycles before ready -> o_icache_pc constant over those cycles, then one push with PC unchanged, and PC+4 on the ready edge.
- Jump during miss: i_jump with i_jump_pc=0x1003 while bus_request is high -> FIFO empty, stall=1, the late ready is discarded, the PC is held until 2 quiet cycles, then o_icache_pc=0x1000 and state RUN.
- Jump coincident with ready and pop: FIFO empties, fetched word is not pushed, fetch_pc is not incremented; a second jump to 0x2000 one cycle later -> final o_icache_pc=0x2000.
- Reset asserted mid-FLUSH with 3 entries held earlier -> next cycle o_valid=0, o_icache_pc=RESET_PC, stall=0.

Source files
------------

// File: rtl/cpu_fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, buffers cache responses with
// their PCs in a first-word-fall-through FIFO, and performs flush-and-drain redirects.
module cpu_fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_icache_pc,
  output logic        o_icache_stall,
  input  logic [31:0] i_icache_rdata,
  input  logic        i_icache_ready,
  input  logic        i_icache_bus_request,
  input  logic        i_jump,
  input  logic [31:0] i_jump_pc,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  input  logic        i_ready
);

  localparam int                  DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] STALL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state, state_next;
  logic [31:0]           fetch_pc, pc_next;
  logic [31:0]           target, target_next;
  logic [1:0]            quiet, quiet_next;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic                  push, pop, push_ok, flush_fifo;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic unused_jump_bits;
  assign unused_jump_bits = ^i_jump_pc[1:0];

  assign o_icache_pc    = fetch_pc;
  assign o_valid        = (count != '0);
  assign o_pc           = o_valid ? pc_mem[rd_ptr]    : '0;
  assign o_instruction  = o_valid ? instr_mem[rd_ptr] : '0;
  // The margin of one entry absorbs the response the cache may still return
  // after it last sampled stall low.
  assign o_icache_stall = (state == FLUSH) || (count >= STALL_COUNT);
  assign push_ok        = push && (count != FULL_COUNT);

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= RUN;
    else         state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_next  = state;
    pc_next     = fetch_pc;
    target_next = target;
    quiet_next  = quiet;
    push        = 1'b0;
    pop         = 1'b0;
    flush_fifo  = 1'b0;
    case (state)
      RUN: begin
        if (i_jump) begin
          target_next = {i_jump_pc[31:2], 2'b00};
          flush_fifo  = 1'b1;
          quiet_next  = '0;
          state_next  = FLUSH;
        end else begin
          pop = o_valid && i_ready;
          if (i_icache_ready) begin
            push    = 1'b1;
            pc_next = fetch_pc + 32'd4;
          end
        end
      end
      FLUSH: begin
        if (i_jump) target_next = {i_jump_pc[31:2], 2'b00};
        if (i_icache_ready || i_icache_bus_request) begin
          quiet_next = '0;
        end else if (quiet == 2'd1) begin
          // Second consecutive quiet cycle: the cache is drained, so redirect now.
          pc_next    = target_next;
          quiet_next = '0;
          state_next = RUN;
        end else begin
          quiet_next = quiet + 2'd1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (i_reset) begin
      fetch_pc <= RESET_PC;
      target   <= '0;
      quiet    <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      fetch_pc <= pc_next;
      target   <= target_next;
      quiet    <= quiet_next;
      if (flush_fifo) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage array is not reset; count gates every read, so stale words are never visible.
  always_ff @(posedge i_clock) begin
    if (push_ok) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= i_icache_rdata;
    end
  end

  no_overflow: assert property (@(posedge i_clock) disable iff (i_reset)
                                !(push && count == FULL_COUNT));

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Self-checking bench for cpu_fetch_queue: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_cpu_fetch_queue;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          DEPTH_LOG2 = 2;
  localparam int          DEPTH      = 1 << DEPTH_LOG2;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] o_icache_pc;
  logic        o_icache_stall;
  logic [31:0] i_icache_rdata;
  logic        i_icache_ready;
  logic        i_icache_bus_request;
  logic        i_jump;
  logic [31:0] i_jump_pc;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        i_ready;

  cpu_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .i_clock              (i_clock),
    .i_reset              (i_reset),
    .o_icache_pc          (o_icache_pc),
    .o_icache_stall       (o_icache_stall),
    .i_icache_rdata       (i_icache_rdata),
    .i_icache_ready       (i_icache_ready),
    .i_icache_bus_request (i_icache_bus_request),
    .i_jump               (i_jump),
    .i_jump_pc            (i_jump_pc),
    .o_valid              (o_valid),
    .o_pc                 (o_pc),
    .o_instruction        (o_instruction),
    .i_ready              (i_ready)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model: decode-visible queue, fetch PC and redirect bookkeeping.
  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_target;
  int          m_quiet;
  bit          m_flushing;
  logic        last_stall;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_stall();
    return m_flushing || (m_q.size() >= DEPTH - 1);
  endfunction

  task automatic model_step();
    bit do_pop, room;
    if (i_reset) begin
      m_q.delete();
      m_pc       = RESET_PC;
      m_target   = '0;
      m_quiet    = 0;
      m_flushing = 0;
    end else if (!m_flushing) begin
      if (i_jump) begin
        m_target   = i_jump_pc & 32'hFFFF_FFFC;
        m_q.delete();
        m_quiet    = 0;
        m_flushing = 1;
      end else begin
        do_pop = (m_q.size() != 0) && i_ready;
        room   = (m_q.size() < DEPTH);
        if (do_pop) void'(m_q.pop_front());
        if (i_icache_ready) begin
          if (room) m_q.push_back('{pc: m_pc, instr: i_icache_rdata});
          m_pc = m_pc + 32'd4;
        end
      end
    end else begin
      if (i_jump) m_target = i_jump_pc & 32'hFFFF_FFFC;
      if (i_icache_ready || i_icache_bus_request) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == 2) begin
          m_pc       = m_target;
          m_quiet    = 0;
          m_flushing = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    entry_t head;
    logic   ev;
    ev   = (m_q.size() != 0);
    head = ev ? m_q[0] : '0;
    check("icache_pc",   o_icache_pc,    m_pc);
    check("stall",       o_icache_stall, exp_stall());
    check("valid",       o_valid,        ev);
    check("head_pc",     o_pc,           head.pc);
    check("head_instr",  o_instruction,  head.instr);
  endtask

  task automatic tick();
    last_stall = exp_stall();
    model_step();
    @(posedge i_clock);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic rst, input logic jmp, input logic [31:0] jpc,
                       input logic rdy, input logic [31:0] rdata,
                       input logic busreq, input logic dec_rdy);
    i_reset              = rst;
    i_jump               = jmp;
    i_jump_pc            = jpc;
    i_icache_ready       = rdy;
    i_icache_rdata       = rdata;
    i_icache_bus_request = busreq;
    i_ready              = dec_rdy;
  endtask

  initial begin
    logic [31:0] held_pc;
    last_stall = 1'b0;
    m_pc       = RESET_PC;
    m_target   = '0;
    m_quiet    = 0;
    m_flushing = 0;

    // Reset
    drive(1, 0, '0, 0, '0, 0, 0);
    tick();
    tick();

    // Hit stream with decode always ready
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, '0, 1, 32'hA0 + 32'(i), 0, 1);
      tick();
    end
    drive(0, 0, '0, 0, '0, 0, 1);
    tick();

    // Backpressure: cache answers only after seeing stall low
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, '0, !last_stall, 32'hB0 + 32'(i), 0, 0);
      tick();
    end
    check("bp_stall_high", o_icache_stall, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, '0, 0, '0, 0, 1);
      tick();
    end

    // Miss hold: PC stable while the bus request is in flight
    held_pc = m_pc;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, '0, 0, '0, 1, 1);
      tick();
    end
    check("miss_hold_pc", o_icache_pc, held_pc);
    drive(0, 0, '0, 1, 32'hC0, 0, 0);
    tick();
    drive(0, 0, '0, 0, '0, 0, 1);
    tick();

    // Jump during a miss, with a late response that must be discarded
    drive(0, 0, '0, 0, '0, 1, 1);
    tick();
    drive(0, 1, 32'h0000_1003, 0, '0, 1, 1);
    tick();
    drive(0, 0, '0, 0, '0, 1, 1);
    tick();
    tick();
    drive(0, 0, '0, 1, 32'hDEAD_BEEF, 0, 1);
    tick();
    drive(0, 0, '0, 0, '0, 0, 1);
    tick();
    tick();
    check("jump_target_pc", o_icache_pc, 32'h0000_1000);

    // Jump coincident with response and pop, then a second jump
    drive(0, 0, '0, 1, 32'hE0, 0, 0);
    tick();
    drive(0, 0, '0, 1, 32'hE1, 0, 0);
    tick();
    drive(0, 1, 32'h0000_1800, 1, 32'hE2, 0, 1);
    tick();
    check("jump_flush_valid", o_valid, 1'b0);
    drive(0, 1, 32'h0000_2000, 0, '0, 0, 1);
    tick();
    drive(0, 0, '0, 0, '0, 0, 1);
    tick();
    check("second_jump_pc", o_icache_pc, 32'h0000_2000);

    // Reset while flushing, three entries held beforehand
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, 1, 32'hF0 + 32'(i), 0, 0);
      tick();
    end
    drive(0, 1, 32'h0000_3000, 0, '0, 1, 0);
    tick();
    drive(0, 0, '0, 0, '0, 1, 0);
    tick();
    drive(1, 0, '0, 0, '0, 1, 0);
    tick();
    check("rst_valid", o_valid, 1'b0);
    check("rst_pc",    o_icache_pc, RESET_PC);
    check("rst_stall", o_icache_stall, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 19) == 0),
            $urandom,
            !last_stall && ($urandom_range(0, 2) != 0),
            $urandom,
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
